// File: rtl/pacman_ctrl.sv
// pacman_ctrl: player movement on an 8-px grid, monster collision, lives.
// In: clk, rst_n, dir_req/dir_valid, blocked, m_x/m_y. Out: p_x/p_y, cur_dir, lives, dead, game_over.
module pacman_ctrl #(
  parameter int         STEP_DIV     = 250000,
  parameter logic [8:0] START_X      = 9'd152,
  parameter logic [8:0] START_Y      = 9'd232,
  parameter int         HIT_DIST     = 6,
  parameter logic [1:0] LIVES        = 2'd3,
  parameter int         FREEZE_TICKS = 32,
  parameter logic [8:0] X_MAX        = 9'd304,
  parameter logic [8:0] Y_MAX        = 9'd240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] dir_req,
  input  logic       dir_valid,
  input  logic [3:0] blocked,
  input  logic [8:0] m_x,
  input  logic [8:0] m_y,
  output logic [8:0] p_x,
  output logic [8:0] p_y,
  output logic [1:0] cur_dir,
  output logic [1:0] lives,
  output logic       dead,
  output logic       game_over
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int FW = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(STEP_DIV - 1);
  localparam logic [FW-1:0] FMAX = FW'(FREEZE_TICKS - 1);
  localparam logic [9:0] HD = 10'(HIT_DIST);

  typedef enum logic [1:0] {RUN, HIT, FREEZE, OVER} state_t;

  state_t state, state_nx;

  logic [PW-1:0] pcnt;
  logic [FW-1:0] fcnt;
  logic          tick;
  logic [1:0]    pend;
  logic          pend_v;
  logic          aligned;
  logic          take;
  logic [1:0]    new_dir;
  logic [8:0]    nx, ny;
  logic [9:0]    dx, dy;
  logic          hit;

  assign tick    = (pcnt == PMAX);
  assign aligned = (p_x[2:0] == 3'd0) && (p_y[2:0] == 3'd0);

  assign dx = (p_x >= m_x) ? ({1'b0, p_x} - {1'b0, m_x})
                           : ({1'b0, m_x} - {1'b0, p_x});
  assign dy = (p_y >= m_y) ? ({1'b0, p_y} - {1'b0, m_y})
                           : ({1'b0, m_y} - {1'b0, p_y});
  assign hit = (dx < HD) && (dy < HD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt <= '0;
    else if (tick) pcnt <= '0;
    else pcnt <= pcnt + PW'(1);
  end

  // Reversal is always legal; a turn needs grid alignment and an open side.
  always_comb begin
    take = 1'b0;
    if (pend_v && (pend == (cur_dir ^ 2'd2))) take = 1'b1;
    else if (pend_v && aligned && !blocked[pend]) take = 1'b1;
    new_dir = take ? pend : cur_dir;
    nx = p_x;
    ny = p_y;
    if (!(aligned && blocked[new_dir])) begin
      unique case (new_dir)
        2'd0: if (p_y != 9'd0) ny = p_y - 9'd1;
        2'd1: if (p_x < X_MAX) nx = p_x + 9'd1;
        2'd2: if (p_y < Y_MAX) ny = p_y + 9'd1;
        2'd3: if (p_x != 9'd0) nx = p_x - 9'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:    if (hit) state_nx = HIT;
      HIT:    state_nx = (lives <= 2'd1) ? OVER : FREEZE;
      FREEZE: if (tick && fcnt == FMAX) state_nx = RUN;
      OVER:   state_nx = OVER;
    endcase
  end

  always_comb begin
    dead      = (state == HIT);
    game_over = (state == OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_x     <= START_X;
      p_y     <= START_Y;
      cur_dir <= 2'd3;
      lives   <= LIVES;
      pend    <= 2'd0;
      pend_v  <= 1'b0;
      fcnt    <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!hit && tick) begin
            cur_dir <= new_dir;
            p_x     <= nx;
            p_y     <= ny;
            if (take) pend_v <= 1'b0;
          end
          if (dir_valid) begin
            pend   <= dir_req;
            pend_v <= 1'b1;
          end
        end
        HIT: begin
          if (lives != 2'd0) lives <= lives - 2'd1;
          if (state_nx == FREEZE) begin
            p_x     <= START_X;
            p_y     <= START_Y;
            cur_dir <= 2'd3;
            pend_v  <= 1'b0;
            fcnt    <= '0;
          end
        end
        FREEZE: begin
          if (tick) fcnt <= (fcnt == FMAX) ? '0 : fcnt + FW'(1);
        end
        OVER: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_ctrl.sv
// tb_pacman_ctrl: directed stimulus, per-cycle model compare, literal pins.
// Runs with STEP_DIV=4 and FREEZE_TICKS=2.
module tb_pacman_ctrl;

  localparam int SD = 4;
  localparam int FT = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] dir_req;
  logic       dir_valid;
  logic [3:0] blocked;
  logic [8:0] m_x, m_y;
  logic [8:0] p_x, p_y;
  logic [1:0] cur_dir;
  logic [1:0] lives;
  logic       dead;
  logic       game_over;

  int ncmp = 0;
  int nerr = 0;

  pacman_ctrl #(.STEP_DIV(SD), .FREEZE_TICKS(FT)) dut (
    .clk(clk), .rst_n(rst_n),
    .dir_req(dir_req), .dir_valid(dir_valid),
    .blocked(blocked), .m_x(m_x), .m_y(m_y),
    .p_x(p_x), .p_y(p_y), .cur_dir(cur_dir),
    .lives(lives), .dead(dead), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 playing, 1 hit cycle, 2 frozen, 3 game over.
  int mpx, mpy, mdir, mlives, mpend, mpv, mode, mfrz, mcyc;
  bit mtk;

  function automatic int adist(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_move();
    bit al;
    al = (mpx % 8 == 0) && (mpy % 8 == 0);
    if (mpv != 0 && (mpend == (mdir + 2) % 4 || (al && !blocked[mpend]))) begin
      mdir = mpend;
      mpv = 0;
    end
    if (!(al && blocked[mdir])) begin
      case (mdir)
        0: if (mpy > 0) mpy = mpy - 1;
        1: if (mpx < 304) mpx = mpx + 1;
        2: if (mpy < 240) mpy = mpy + 1;
        default: if (mpx > 0) mpx = mpx - 1;
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mpx = 152; mpy = 232; mdir = 3; mlives = 3;
      mpend = 0; mpv = 0; mode = 0; mfrz = 0; mcyc = 0;
    end else begin
      mtk = (mcyc % SD) == SD - 1;
      mcyc = mcyc + 1;
      case (mode)
        0: begin
          if (adist(mpx, m_x) < 6 && adist(mpy, m_y) < 6) mode = 1;
          else if (mtk) model_move();
          if (dir_valid) begin
            mpend = dir_req;
            mpv = 1;
          end
        end
        1: begin
          mlives = mlives - 1;
          if (mlives == 0) mode = 3;
          else begin
            mode = 2; mfrz = 0; mpv = 0;
            mpx = 152; mpy = 232; mdir = 3;
          end
        end
        2: if (mtk) begin
          mfrz = mfrz + 1;
          if (mfrz == FT) mode = 0;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    #1;
    ncmp = ncmp + 1;
    if (p_x !== 9'(mpx) || p_y !== 9'(mpy) || cur_dir !== 2'(mdir) ||
        lives !== 2'(mlives) || dead !== (mode == 1) ||
        game_over !== (mode == 3)) begin
      nerr = nerr + 1;
      $display("FAIL model t=%0t: got p=(%0d,%0d) dir=%0d lives=%0d dead=%0b go=%0b, need p=(%0d,%0d) dir=%0d lives=%0d dead=%0b go=%0b",
               $time, p_x, p_y, cur_dir, lives, dead, game_over,
               mpx, mpy, mdir, mlives, mode == 1, mode == 3);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    ncmp = ncmp + 1;
    if (act != exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0d, need %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [1:0] d);
    dir_req = d;
    dir_valid = 1'b1;
    cyc(1);
    dir_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dir_req = 2'd0; dir_valid = 1'b0;
    blocked = 4'd0; m_x = 9'd0; m_y = 9'd0;
    cyc(2);
    chk("rst_px", p_x, 152);
    chk("rst_py", p_y, 232);
    chk("rst_dir", cur_dir, 3);
    chk("rst_lives", lives, 3);
    chk("rst_dead", dead, 0);
    chk("rst_over", game_over, 0);
    rst_n = 1'b1;

    // eight ticks drifting left
    cyc(32);
    chk("t1_px", p_x, 144);
    chk("t1_py", p_y, 232);
    chk("t1_dir", cur_dir, 3);

    // turn request held until the grid point
    do_reset();
    cyc(16);
    chk("t2_px148", p_x, 148);
    strobe(2'd0);
    cyc(15);
    chk("t2_px144", p_x, 144);
    chk("t2_py232", p_y, 232);
    cyc(4);
    chk("t2_py231", p_y, 231);
    chk("t2_dir", cur_dir, 0);

    // wall ahead holds position, reversal escapes
    do_reset();
    cyc(32);
    blocked = 4'b1000;
    cyc(16);
    chk("t3_hold", p_x, 144);
    strobe(2'd1);
    cyc(3);
    chk("t3_px145", p_x, 145);
    chk("t3_dir", cur_dir, 1);
    blocked = 4'd0;

    // single collision and respawn
    do_reset();
    strobe(2'd1);
    cyc(15);
    chk("t4_px156", p_x, 156);
    m_x = 9'd150; m_y = 9'd230;
    strobe(2'd3);
    cyc(3);
    chk("t4_px155", p_x, 155);
    chk("t4_nodead", dead, 0);
    cyc(1);
    chk("t4_dead", dead, 1);
    m_x = 9'd0; m_y = 9'd0;
    cyc(1);
    chk("t4_dead_off", dead, 0);
    chk("t4_lives", lives, 2);
    chk("t4_respawn", p_x, 152);
    cyc(6);
    chk("t4_frozen", p_x, 152);
    cyc(4);
    chk("t4_moves", p_x, 151);

    // three hits to game over, reset recovers
    m_x = 9'd152; m_y = 9'd232;
    do_reset();
    cyc(30);
    chk("t5_lives", lives, 0);
    chk("t5_over", game_over, 1);
    m_x = 9'd0; m_y = 9'd0;
    strobe(2'd1);
    cyc(8);
    chk("t5_px", p_x, 152);
    chk("t5_still_over", game_over, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_lives", lives, 3);
    chk("t5_rst_over", game_over, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);

    // reset during the hit cycle, then during freeze
    m_x = 9'd152; m_y = 9'd232;
    do_reset();
    cyc(1);
    chk("t6_hit", dead, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_hit_rst", dead, 0);
    m_x = 9'd0; m_y = 9'd0;
    cyc(2);
    rst_n = 1'b1;
    cyc(8);
    chk("t6_lives", lives, 3);
    m_x = 9'd152; m_y = 9'd232;
    do_reset();
    cyc(3);
    chk("t6_frz_lives", lives, 2);
    rst_n = 1'b0;
    m_x = 9'd0; m_y = 9'd0;
    #1;
    chk("t6_frz_rst", lives, 3);
    cyc(2);
    rst_n = 1'b1;
    cyc(12);

    // run up into the top edge
    do_reset();
    strobe(2'd0);
    cyc(1000);
    chk("t7_top", p_y, 0);
    chk("t7_px", p_x, 152);
    chk("t7_dir", cur_dir, 0);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/pacman_ctrl.md
PACMAN_CTRL -- requirements
Module: pacman_ctrl

Interface
REQ-001 Parameter STEP_DIV, default 250000: clk cycles per movement tick.
REQ-002 Parameter START_X, default 9'd152: respawn x in pixels.
REQ-003 Parameter START_Y, default 9'd232: respawn y in pixels.
REQ-004 Parameter HIT_DIST, default 6: collision distance threshold in pixels.
REQ-005 Parameter LIVES, default 3: initial life count.
REQ-006 Parameter FREEZE_TICKS, default 32: ticks frozen after a hit.
REQ-007 Parameters X_MAX = 9'd304 and Y_MAX = 9'd240: inclusive position limits.
REQ-008 clk  input  1  system clock; the only clock, all state on its rising edge.
REQ-009 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-010 dir_req  input  2  requested direction: 0 up, 1 right, 2 down, 3 left.
REQ-011 dir_valid  input  1  one-cycle strobe qualifying dir_req.
REQ-012 blocked  input  4  wall flags for the current tile; bit n set means direction n is blocked.
REQ-013 m_x, m_y  input  9 each  monster position (from monster block).
REQ-014 p_x, p_y  output  9 each  player position (feeds monster block).
REQ-015 cur_dir  output  2  current movement direction.
REQ-016 lives  output  2  remaining lives.
REQ-017 dead  output  1  one-cycle pulse on each collision.
REQ-018 game_over  output  1  high while in OVER.

Function
REQ-019 Prescaler SHALL count 0..STEP_DIV-1 and assert internal tick for one cycle at STEP_DIV-1, then wrap to 0; it runs in every state.
REQ-020 FSM states SHALL be RUN, HIT, FREEZE, OVER; reset state RUN.
REQ-021 dir_valid SHALL latch dir_req into a pending register with pending-valid set; a later strobe overwrites it (last wins).
REQ-022 aligned SHALL mean p_x[2:0]==0 and p_y[2:0]==0 (8-pixel grid).
REQ-023 On tick in RUN, a pending direction exactly opposite cur_dir SHALL be adopted regardless of alignment; pending-valid then clears.
REQ-024 On tick in RUN, when aligned, pending valid and blocked[pending]==0, cur_dir SHALL take pending and pending-valid clears; if blocked, pending stays held.
REQ-025 After REQ-023/024, the player SHALL move 1 pixel in cur_dir unless (aligned and blocked[cur_dir]) or the move would leave 0..X_MAX / 0..Y_MAX; otherwise position holds.
REQ-026 Up decrements p_y, down increments p_y, right increments p_x, left decrements p_x; no wrap-around.
REQ-027 Collision SHALL be |p_x-m_x|<HIT_DIST and |p_y-m_y|<HIT_DIST, computed as unsigned 10-bit differences, evaluated every cycle in RUN.
REQ-028 Collision in RUN SHALL take priority over a same-cycle tick: no move, next state HIT.
REQ-029 HIT lasts exactly one cycle: dead=1, lives decrements by 1; next state OVER if lives was 1, else FREEZE.
REQ-030 On entry to FREEZE, p_x/p_y SHALL load START_X/START_Y, cur_dir=3, pending-valid clears; dir_valid is ignored.
REQ-031 FREEZE SHALL count FREEZE_TICKS ticks and return to RUN on the cycle after the last; no collision check in FREEZE.
REQ-032 OVER SHALL hold all outputs, assert game_over, ignore all inputs; exit only via rst_n.
REQ-033 lives SHALL never underflow; it is never decremented below 0.

Reset
REQ-034 While rst_n=0: p_x=START_X, p_y=START_Y, cur_dir=3, lives=LIVES, dead=0, game_over=0, prescaler=0, pending-valid=0, freeze count=0, state RUN.
REQ-035 Reset asserted mid-FREEZE or mid-HIT SHALL take effect immediately, with no dead pulse emitted afterward.

Verification (STEP_DIV=4, FREEZE_TICKS=2, m_x=m_y=0 unless stated)
REQ-036 Reset release, blocked=0, no requests, 8 ticks -> p_x 152->144, p_y=232, cur_dir=3.
REQ-037 At p=(148,232) moving left, dir_req=0 strobed, blocked=0 -> left continues to p_x=144, then up: p_y 232->231 on the following tick.
REQ-038 At p=(144,232), blocked=4'b1000, cur_dir=3 -> position holds across 4 ticks; a dir_req=1 strobe then moves p_x to 145 on the next tick.
REQ-039 m=(150,230), p reaches (155,232) -> dead pulses once, lives 3->2, p=(152,232) next cycle, no motion for 2 ticks, then moves.
REQ-040 m=(152,232) held, three hits -> lives 3->2->1->0, game_over=1, p frozen; rst_n pulse restores lives=3, game_over=0.
